// File: rtl/fdm_pkg.sv
// rtl/fdm_pkg.sv - FSM encoding, mode_det codes and default period constants for freq_duty_meter
package fdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } fdm_state_e;

  localparam logic [1:0] MODE_UNK = 2'b00;
  localparam logic [1:0] MODE_A   = 2'b01;
  localparam logic [1:0] MODE_B   = 2'b10;

  localparam int FDM_PERIOD_A = 4245;
  localparam int FDM_PERIOD_B = 28121;
  localparam int FDM_TOL      = 8;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - 2-flop synchronizer plus registered rise/fall detector
module sync_edge_det (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic sync1, sync2, prev;

  // Edge pulses appear after the 3rd clock edge that sees the new level.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
      rise  <= sync2 & ~prev;
      fall  <= ~sync2 & prev;
    end
  end

endmodule

// File: rtl/freq_duty_meter.sv
// rtl/freq_duty_meter.sv - period/high-time meter with divider mode classification
// Optional duty_ok output enabled by DUTY_CHECK_EN.
module freq_duty_meter
  import fdm_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int PERIOD_A = FDM_PERIOD_A,
  parameter int PERIOD_B = FDM_PERIOD_B,
  parameter int TOL      = FDM_TOL
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic [1:0]       mode_det,
  output logic             timeout
`ifdef DUTY_CHECK_EN
  ,
  output logic             duty_ok
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   PA_W    = (CNT_W+1)'(PERIOD_A);
  localparam logic [CNT_W:0]   PB_W    = (CNT_W+1)'(PERIOD_B);
  localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);

  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W:0] a, input logic [CNT_W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] p);
    logic [CNT_W:0] pe;
    pe = {1'b0, p};
    if (abs_diff(pe, PA_W) <= TOL_W) return MODE_A;
    if (abs_diff(pe, PB_W) <= TOL_W) return MODE_B;
    return MODE_UNK;
  endfunction

  logic rise, fall;

  sync_edge_det u_sync_edge_det (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  fdm_state_e       state, state_nxt;
  logic             do_start, do_meas, do_timeout, inc_high;
  logic [CNT_W-1:0] cnt, hcnt, high_sel;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A rise wins over saturation so a period of exactly CNT_MAX is still measured.
  always_comb begin
    state_nxt  = state;
    do_start   = 1'b0;
    do_meas    = 1'b0;
    do_timeout = 1'b0;
    inc_high   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_HIGH;
          do_start  = 1'b1;
        end
      end
      ST_HIGH: begin
        if (rise) begin
          do_meas = 1'b1;
        end else if (cnt == CNT_MAX) begin
          do_timeout = 1'b1;
          state_nxt  = ST_IDLE;
        end else if (fall) begin
          state_nxt = ST_LOW;
        end else begin
          inc_high = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise) begin
          do_meas   = 1'b1;
          state_nxt = ST_HIGH;
        end else if (cnt == CNT_MAX) begin
          do_timeout = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A rise while still HIGH means the fall was missed: the whole period counts as high.
  assign high_sel = (state == ST_HIGH) ? cnt : hcnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      hcnt       <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      mode_det   <= MODE_UNK;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (do_timeout) begin
        cnt      <= '0;
        hcnt     <= '0;
        timeout  <= 1'b1;
        mode_det <= MODE_UNK;
      end else if (do_start) begin
        cnt  <= CNT_ONE;
        hcnt <= CNT_ONE;
      end else if (do_meas) begin
        period_cnt <= cnt;
        high_cnt   <= high_sel;
        meas_valid <= 1'b1;
        mode_det   <= classify(cnt);
        cnt        <= CNT_ONE;
        hcnt       <= CNT_ONE;
      end else if (state != ST_IDLE) begin
        cnt <= cnt + CNT_ONE;
        if (inc_high) hcnt <= hcnt + CNT_ONE;
      end
    end
  end

`ifdef DUTY_CHECK_EN
  localparam int             DW   = CNT_W + 4;
  localparam logic [DW-1:0]  TOL5 = DW'(5 * TOL);

  // 20% duty: 5*high must sit within period +/- 5*TOL, computed wide enough not to wrap.
  function automatic logic duty_in_range(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] h);
    logic [DW-1:0] h5, pw;
    h5 = ({4'b0000, h} << 2) + {4'b0000, h};
    pw = {4'b0000, p};
    return ((h5 >= pw) ? (h5 - pw) : (pw - h5)) <= TOL5;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)       duty_ok <= 1'b0;
    else if (do_meas) duty_ok <= duty_in_range(cnt, high_sel);
  end
`endif

endmodule

// File: tb/tb_freq_duty_meter.sv
// tb/tb_freq_duty_meter.sv - randomized bench for freq_duty_meter against a timing-level model
module tb_freq_duty_meter;

  localparam int CNT_W = 15;
  localparam int PA    = 4245;
  localparam int PB    = 28121;
  localparam int TOL   = 8;
  localparam int TMAX  = (1 << CNT_W) - 1;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             sig_in;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic             meas_valid, timeout;
  logic [1:0]       mode_det;
`ifdef DUTY_CHECK_EN
  logic             duty_ok;
`endif

  int total = 0;
  int bad   = 0;

  freq_duty_meter #(.CNT_W(CNT_W)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .mode_det   (mode_det),
    .timeout    (timeout)
`ifdef DUTY_CHECK_EN
    ,
    .duty_ok    (duty_ok)
`endif
  );

  always #5 clk_in = ~clk_in;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int mode_of(input int p);
    if (iabs(p - PA) <= TOL) return 1;
    if (iabs(p - PB) <= TOL) return 2;
    return 0;
  endfunction

  task automatic check_val(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Model works in clock-edge timestamps: a sig_in edge first sampled at edge k acts on the FSM at edge k+3.
  int   ecount = 0;
  int   t_rise = 0;
  int   t_fall = -1;
  bit   armed  = 1'b0;
  logic [4:0] h = '0;
  int   m_per = 0, m_hi = 0, m_mode = 0;
  bit   m_mv = 1'b0, m_to = 1'b0;
`ifdef DUTY_CHECK_EN
  bit   m_duty = 1'b0;
`endif
  int   n_mv = 0, n_to = 0;
  int   cap_per = 0, cap_hi = 0, cap_mode = 0;

  initial begin
    logic [2*CNT_W+3:0] got, want;
    bit rise_e, fall_e;
    forever begin
      @(posedge clk_in);
      ecount++;
      if (!rst_n) begin
        h = '0; armed = 1'b0; t_fall = -1;
        m_per = 0; m_hi = 0; m_mode = 0; m_mv = 1'b0; m_to = 1'b0;
`ifdef DUTY_CHECK_EN
        m_duty = 1'b0;
`endif
      end else begin
        h = {h[3:0], sig_in};
        rise_e = h[3] & ~h[4];
        fall_e = ~h[3] & h[4];
        m_mv = 1'b0;
        m_to = 1'b0;
        if (rise_e) begin
          if (armed) begin
            m_per  = ecount - t_rise;
            m_hi   = (t_fall >= 0) ? (t_fall - t_rise) : m_per;
            m_mode = mode_of(m_per);
            m_mv   = 1'b1;
`ifdef DUTY_CHECK_EN
            m_duty = (iabs(5 * m_hi - m_per) <= 5 * TOL);
`endif
          end
          armed  = 1'b1;
          t_rise = ecount;
          t_fall = -1;
        end else if (armed && (ecount - t_rise == TMAX)) begin
          m_to   = 1'b1;
          m_mode = 0;
          armed  = 1'b0;
        end else if (fall_e && armed && t_fall < 0) begin
          t_fall = ecount;
        end
      end
      #1;
      got  = {meas_valid, timeout, mode_det, period_cnt, high_cnt};
      want = {m_mv, m_to, 2'(m_mode), CNT_W'(m_per), CNT_W'(m_hi)};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL outputs edge %0d: got mv=%0b to=%0b mode=%0d per=%0d hi=%0d want mv=%0b to=%0b mode=%0d per=%0d hi=%0d",
                 ecount, meas_valid, timeout, mode_det, period_cnt, high_cnt, m_mv, m_to, m_mode, m_per, m_hi);
      end
`ifdef DUTY_CHECK_EN
      total++;
      if (duty_ok !== m_duty) begin
        bad++;
        $display("FAIL duty_ok edge %0d: got %0b want %0b", ecount, duty_ok, m_duty);
      end
`endif
      if (meas_valid === 1'b1) begin
        n_mv++;
        cap_per  = int'(period_cnt);
        cap_hi   = int'(high_cnt);
        cap_mode = int'(mode_det);
      end
      if (timeout === 1'b1) n_to++;
    end
  end

  task automatic hold(input logic lvl, input int n);
    sig_in = lvl;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pulse(input int hi, input int per);
    hold(1'b1, hi);
    hold(1'b0, per - hi);
  endtask

  task automatic check_cap(input string name, input int per, input int hi, input int mode);
    check_val({name, "_period"}, cap_per, per);
    check_val({name, "_high"}, cap_hi, hi);
    check_val({name, "_mode"}, cap_mode, mode);
  endtask

  task automatic check_zero(input string name);
    check_val({name, "_period_cnt"}, int'(period_cnt), 0);
    check_val({name, "_high_cnt"}, int'(high_cnt), 0);
    check_val({name, "_mode_det"}, int'(mode_det), 0);
    check_val({name, "_meas_valid"}, int'(meas_valid), 0);
    check_val({name, "_timeout"}, int'(timeout), 0);
`ifdef DUTY_CHECK_EN
    check_val({name, "_duty_ok"}, int'(duty_ok), 0);
`endif
  endtask

  initial begin
    int mv0, to0, hi_r, per_r;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (4) @(negedge clk_in);
    check_zero("reset");
    rst_n = 1'b1;
    hold(1'b0, 10);

    mv0 = n_mv;
    pulse(849, PA);
    per_r = PA + int'($urandom_range(24)) - 12;
    hi_r  = 800 + int'($urandom_range(100));
    pulse(hi_r, per_r);
    check_val("first_rise_no_meas", n_mv - mv0, 1);
    check_cap("mode_a", 4245, 849, 1);
`ifdef DUTY_CHECK_EN
    check_val("mode_a_duty", int'(duty_ok), 1);
`endif

    pulse(500, 1000);
    hi_r  = 20 + int'($urandom_range(580));
    per_r = hi_r + 20 + int'($urandom_range(880));
    pulse(hi_r, per_r);
    check_cap("p1000", 1000, 500, 0);
`ifdef DUTY_CHECK_EN
    check_val("p1000_duty", int'(duty_ok), 0);
`endif
    for (int i = 0; i < 4; i++) begin
      hi_r  = 20 + int'($urandom_range(580));
      per_r = hi_r + 20 + int'($urandom_range(880));
      pulse(hi_r, per_r);
    end

    pulse(849, 1849);
    mv0 = n_mv;
    pulse(5625, PB);
    check_val("mixed_meas_count", n_mv - mv0, 1);
    check_cap("mixed", 1849, 849, 0);
    hold(1'b1, 5625);
    check_cap("mode_b", 28121, 5625, 2);

    mv0 = n_mv;
    to0 = n_to;
    hold(1'b0, 27200);
    check_val("timeout_count", n_to - to0, 1);
    check_val("timeout_no_meas", n_mv - mv0, 0);
    check_val("timeout_mode", int'(mode_det), 0);
    check_val("timeout_held_period", int'(period_cnt), 28121);
    check_val("timeout_held_high", int'(high_cnt), 5625);
    mv0 = n_mv;
    pulse(100, 200);
    check_val("post_timeout_first_rise", n_mv - mv0, 0);

    hold(1'b1, 100);
    rst_n = 1'b0;
    #1;
    check_zero("mid_high_reset");
    sig_in = 1'b0;
    repeat (5) @(negedge clk_in);
    rst_n = 1'b1;
    hold(1'b0, 10);
    mv0 = n_mv;
    pulse(849, PA);
    hold(1'b1, 10);
    check_val("post_reset_meas_count", n_mv - mv0, 1);
    check_cap("post_reset", 4245, 849, 1);
    hold(1'b0, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
